// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encoding, width defaults and port indices for the data-memory arbiter
package dmem_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } arbState;
    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam logic P_CPU = 1'b0;
    localparam logic P_DBG = 1'b1;
endpackage

// File: rtl/dmem_arbiter_arb_pick.sv
// arb_pick: combinational winner selection between the CPU and debug ports (round-robin when ARB_ROUND_ROBIN_EN is defined, fixed priority otherwise)
module arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic lastOwner,
    output logic win,
    output logic any
);
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the port that was not served last wins; a lone requester always wins
    always_comb begin
        any = req0 | req1;
        win = (req0 && req1) ? ~lastOwner : (req1 ? P_DBG : P_CPU);
    end
`else
    logic unusedLastOwner;
    assign unusedLastOwner = lastOwner;
    // Port 0 always wins a tie; history is ignored
    always_comb begin
        any = req0 | req1;
        win = req0 ? P_CPU : (req1 ? P_DBG : P_CPU);
    end
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises CPU and debug accesses onto a single-port synchronous-read RAM (ARB_ROUND_ROBIN_EN selects round-robin ties)
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);
    arbState state, nextState;
    logic owner, weQ, lastOwner, win, any;

    arb_pick uPick (
        .req0      (req0),
        .req1      (req1),
        .lastOwner (lastOwner),
        .win       (win),
        .any       (any)
    );

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next state: a write finishes after ISSUE, a read needs one more cycle for RAM data
    always_comb begin
        nextState = IDLE;
        case (state)
            IDLE:    nextState = any ? ISSUE : IDLE;
            ISSUE:   nextState = weQ ? IDLE : RDATA;
            default: nextState = IDLE;
        endcase
    end

    // Commit the winning access in IDLE so RAM pins stay stable through ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= P_CPU;
            weQ       <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            lastOwner <= P_DBG;
        end else if (state == IDLE && any) begin
            owner     <= win;
            weQ       <= win ? we1 : we0;
            mem_addr  <= win ? addr1 : addr0;
            mem_din   <= win ? wdata1 : wdata0;
            lastOwner <= win;
        end
    end

    // Moore outputs decoded from registered state and owner
    always_comb begin
        gnt0    = (state == ISSUE) && (owner == P_CPU);
        gnt1    = (state == ISSUE) && (owner == P_DBG);
        rvalid0 = (state == RDATA) && (owner == P_CPU);
        rvalid1 = (state == RDATA) && (owner == P_DBG);
        mem_we  = (state == ISSUE) && weQ;
        rdata   = (state == RDATA) ? mem_dout : '0;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port, synchronous-read DATA_MEMORY (512 × 32-bit) between the processor's load/store port (requester 0) and a debug/loader port (requester 1). It sits between the requesters and the RAM, serialises their accesses with a req/gnt/rvalid handshake and drives the RAM's addr/din/we/dout pins. Each access runs through a three-state FSM, so that at most one access is in flight at a time.

## Interface
- ADDR_W, 9, RAM word-address width
- DATA_W, 32, data width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  access request; held high with stable fields until the matching gnt
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse; access accepted
- rvalid0 / rvalid1  out  1  one-cycle pulse; rdata valid
- rdata  out  DATA_W  read data; shared by both requesters, qualified by rvalidN
- mem_addr  out  ADDR_W  to RAM addr
- mem_din  out  DATA_W  to RAM din
- mem_we  out  1  to RAM we
- mem_dout  in  DATA_W  from RAM dout; valid one cycle after the address is sampled

## Operation
- FSM states: IDLE, ISSUE, RDATA.
- IDLE:
  - With no request pending, stay in IDLE.
  - Otherwise select a winner (see Configuration), then latch owner, addrN→mem_addr, wdataN→mem_din and weN→we_q, and go to ISSUE.
- ISSUE:
  - gnt[owner]=1.
  - mem_we=we_q; mem_addr and mem_din are stable for the whole cycle.
  - If we_q=1, go to IDLE.
  - If we_q=0, go to RDATA.
- RDATA:
  - rvalid[owner]=1 and rdata=mem_dout.
  - Go to IDLE.
- Commit point: the access is committed when latched in IDLE. Dropping req after that point is a protocol violation; the latched access still completes.
- The losing requester keeps req high and is served on the next IDLE cycle.
- last_owner register: updated to owner on each IDLE→ISSUE transition.
- Reset value of every output is 0: gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_addr, mem_din, rdata.
- Reset state: FSM=IDLE, last_owner=1.
- Reset mid-operation: returns to IDLE immediately. An access still in ISSUE and not yet clocked into the RAM is lost and must be re-requested. mem_we drops to 0 asynchronously.

## Timing
- Cycle numbering: cycle 0 = IDLE with req sampled; cycle 1 = ISSUE (gnt); cycle 2 = RDATA (rvalid, reads only).
- Read: req→gnt latency 1 cycle; req→rvalid latency 2 cycles; occupies 3 cycles.
- Write: RAM updated at the rising edge that ends ISSUE; occupies 2 cycles.
- Peak throughput: one write every 2 cycles, one read every 3 cycles.
- gnt and rvalid are Moore outputs decoded from registered state, so there is no combinational path from req to gnt.
- Read-after-write at the same address from either port returns the new data, because the write completes before the next IDLE.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - If both requests are high in IDLE, the winner is the port ≠ last_owner.
  - After reset, port 0 wins the first tie.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority; port 0 always wins a tie.
  - last_owner is still maintained but does not affect arbitration.
- In both modes, a single requester always wins.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, RDATA=2'd2.
  - Defaults for ADDR_W and DATA_W.
  - Port-index constants P_CPU=0, P_DBG=1.
- One sub-module: arb_pick. It is combinational and takes req0, req1 and last_owner. It outputs win (the winning port index) and any (at least one request pending). The ARB_ROUND_ROBIN_EN switch lives inside arb_pick.
- The FSM and the datapath latches stay in dmem_arbiter.

## Test plan
- Single write then read, port 0:
  - Stimulus: write 0xDEADBEEF to addr 0x010, then read addr 0x010.
  - Expect: gnt0 in cycle 1; mem_we=1 only in that cycle.
  - Expect: the read returns rvalid0 two cycles after its req, with rdata=0xDEADBEEF.
- Tie, round-robin build:
  - Stimulus: req0 and req1 both read, held continuously.
  - Expect: grants alternate 0,1,0,1, one grant every 3 cycles.
  - Expect: rvalid never asserts to the non-owner.
- Tie, fixed-priority build (same stimulus):
  - Expect: gnt0 every 3 cycles and gnt1 never.
  - When req0 drops, gnt1 follows within 3 cycles.
- Cross-port coherency:
  - Stimulus: port 1 writes 0x00000055 to addr 0x1FF; port 0 then reads addr 0x1FF.
  - Expect: rdata=0x00000055. Address wrap at 0x1FF is correct.
- Reset mid-operation:
  - Stimulus: assert rst during ISSUE of a write of 0x12345678 to addr 0x020.
  - Expect: all outputs 0 at once; FSM in IDLE.
  - Expect: a subsequent read of 0x020 returns the old contents.
- Idle behaviour:
  - Stimulus: no requests for 20 cycles.
  - Expect: FSM stays in IDLE; mem_we, gnt and rvalid all stay 0.
